// File: rtl/mtp_pkg.sv
// ----------------------------------------------------------------------------
// mtp_pkg : shared types and constants for the MTP responder model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
package mtp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_PROG    = 2'd2,
    ST_ERASE   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W       = 6;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_READ_LAT     = 2;
  localparam int DEF_PROG_CYCLES  = 40;
  localparam int DEF_ERASE_CYCLES = 200;
  localparam int CNT_W            = 16;

  localparam logic [15:0] ERASE_WORD = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge : 2-flop synchronizer with rise/fall pulses on the synced value. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic rd_clock,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge rd_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_prev;
  assign o_fall = ~r_s2 & r_prev;

endmodule
`default_nettype wire

// File: rtl/mtp_resp_model.sv
// ----------------------------------------------------------------------------
// mtp_resp_model : 64x16 MTP macro responder (RD_CLK read, self-timed program, chip erase). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module mtp_resp_model
  import mtp_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LAT     = DEF_READ_LAT,
  parameter int PROG_CYCLES  = DEF_PROG_CYCLES,
  parameter int ERASE_CYCLES = DEF_ERASE_CYCLES
) (
  input  logic              rd_clock,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              oen,
  input  logic              wen,
  input  logic              rd_clk_in,
  input  logic              wsen,
  input  logic              cher,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dbo,
  output logic              ready,
  output logic              err_pulse
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic w_cen_s, w_oen_s, w_wsen_s, w_cher_s;
  logic w_wen_fall, w_rd_rise;
  logic w_unused_cen_rise, w_unused_cen_fall, w_unused_oen_rise, w_unused_oen_fall;
  logic w_unused_wen_s, w_unused_wen_rise, w_unused_rd_s, w_unused_rd_fall;
  logic w_unused_wsen_rise, w_unused_wsen_fall, w_unused_cher_rise, w_unused_cher_fall;

  sync_edge #(.RST_VAL(1'b1)) u_sync_cen (
    .rd_clock(rd_clock), .rst_n(rst_n), .i_async(cen),
    .o_sync(w_cen_s), .o_rise(w_unused_cen_rise), .o_fall(w_unused_cen_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_oen (
    .rd_clock(rd_clock), .rst_n(rst_n), .i_async(oen),
    .o_sync(w_oen_s), .o_rise(w_unused_oen_rise), .o_fall(w_unused_oen_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_wen (
    .rd_clock(rd_clock), .rst_n(rst_n), .i_async(wen),
    .o_sync(w_unused_wen_s), .o_rise(w_unused_wen_rise), .o_fall(w_wen_fall));
  sync_edge #(.RST_VAL(1'b0)) u_sync_rd (
    .rd_clock(rd_clock), .rst_n(rst_n), .i_async(rd_clk_in),
    .o_sync(w_unused_rd_s), .o_rise(w_rd_rise), .o_fall(w_unused_rd_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_wsen (
    .rd_clock(rd_clock), .rst_n(rst_n), .i_async(wsen),
    .o_sync(w_wsen_s), .o_rise(w_unused_wsen_rise), .o_fall(w_unused_wsen_fall));
  sync_edge #(.RST_VAL(1'b0)) u_sync_cher (
    .rd_clock(rd_clock), .rst_n(rst_n), .i_async(cher),
    .o_sync(w_cher_s), .o_rise(w_unused_cher_rise), .o_fall(w_unused_cher_fall));

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]         r_addr, w_addr_nxt;
  logic [DATA_W-1:0]         r_din, w_din_nxt;
  logic [DATA_W-1:0]         r_data, w_data_nxt;
  logic                      r_ready, w_ready_nxt;
  logic                      w_prog_done, w_erase_done, w_err;
  // Array deliberately has no reset: contents survive rst_n like real NVM.
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;

  always_ff @(posedge rd_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_data  <= '0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_din_nxt    = r_din;
    w_data_nxt   = r_data;
    w_ready_nxt  = r_ready;
    w_prog_done  = 1'b0;
    w_erase_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A write strobe always wins over a read strobe in the same detect cycle.
        if (!w_cen_s && w_wen_fall && !w_wsen_s) begin
          w_addr_nxt  = a;
          w_din_nxt   = din;
          w_ready_nxt = 1'b0;
          if (w_cher_s) begin
            w_state_nxt = ST_ERASE;
            w_cnt_nxt   = CNT_W'(ERASE_CYCLES - 1);
          end else begin
            w_state_nxt = ST_PROG;
            w_cnt_nxt   = CNT_W'(PROG_CYCLES - 1);
          end
        end else if (!w_cen_s && w_rd_rise && !w_wen_fall) begin
          w_addr_nxt  = a;
          w_state_nxt = ST_RD_WAIT;
          w_cnt_nxt   = CNT_W'(READ_LAT - 1);
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_data_nxt  = r_mem[r_addr];
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_PROG: begin
        if (r_cnt == '0) begin
          w_prog_done = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        if (r_cnt == '0) begin
          w_erase_done = 1'b1;
          w_ready_nxt  = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
    endcase
    if (w_cen_s) begin
      w_data_nxt = '0;
    end
  end

  always_ff @(posedge rd_clock) begin
    if (w_erase_done) begin
      r_mem <= {DEPTH{DATA_W'(ERASE_WORD)}};
    end else if (w_prog_done) begin
      r_mem[r_addr] <= r_din;
    end
  end

  assign w_err = ((w_rd_rise | w_wen_fall) & ((r_state != ST_IDLE) | w_cen_s))
               | (w_wen_fall & w_wsen_s)
               | (w_rd_rise & w_wen_fall);

  assign dbo       = w_oen_s ? '0 : r_data;
  assign ready     = r_ready;
  assign err_pulse = w_err;

endmodule
`default_nettype wire

// File: doc/mtp_resp_model.md
Name: mtp_resp_model

Overview:
- Synthesizable responder model of the 64x16 MTP macro. It answers the controller-side pins CEN/OEN/WEN/RD_CLK/A and returns DBO and READY.
- Used on the FPGA prototype in place of the hard MTP IP, and as the bench responder for the MTP interface controller.
- Implements read-on-RD_CLK, self-timed word program with READY handshake, and chip erase. Timing is in rd_clock cycles.

Parameters:
- ADDR_W, 6, address width; array depth = 2**ADDR_W words
- DATA_W, 16, word width
- READ_LAT, 2, rd_clock cycles from RD_CLK rise detection to DBO update (1..15)
- PROG_CYCLES, 40, busy cycles for one word program (2..65535)
- ERASE_CYCLES, 200, busy cycles for chip erase (2..65535)

Ports:
- rd_clock  in  1  model clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  chip enable, active low
- oen  in  1  output enable, active low
- wen  in  1  write enable, active low; falling edge starts program/erase
- rd_clk_in  in  1  MTP RD_CLK; rising edge starts read
- wsen  in  1  write select, active low; must be 0 for program/erase
- cher  in  1  chip-erase select, sampled at WEN fall
- a  in  ADDR_W  word address
- din  in  DATA_W  program data
- dbo  out  DATA_W  read data
- ready  out  1  1 = idle; 0 = program/erase in progress
- err_pulse  out  1  one-cycle flag for a rejected request

Behaviour:
- Clock/reset: clock rd_clock, reset rst_n, asynchronous, active-low, as already decided.
- Reset values: dbo=0, ready=1, err_pulse=0, state=IDLE, all counters 0, sync flops 1 for cen/oen/wen and 0 for rd_clk_in.
- Array: no reset. Contents are retained across rst_n as NVM emulation, and read X until written or erased.
- Input sync: cen, oen, wen, rd_clk_in, wsen and cher each pass through a 2-flop synchronizer.
- Edge detect: compare sync stage 2 against its previous value. The detect cycle D is the cycle the edge flag is high.
- Address/din capture: a and din are captured unsynchronized at D. The controller holds them stable across the strobe.
- States: IDLE, RD_WAIT, PROG, ERASE.
- IDLE -> RD_WAIT: rd_clk_in rise with cen_s=0. Latch addr and load cnt=READ_LAT-1.
- RD_WAIT: decrement cnt. At cnt=0, dbo<=mem[addr_lat] and go to IDLE. dbo is therefore updated on the edge ending cycle D+READ_LAT.
- IDLE -> PROG: wen fall with cen_s=0, wsen_s=0, cher_s=0. Latch addr and din, ready<=0 at the edge ending D, cnt=PROG_CYCLES-1.
- PROG: decrement cnt. At cnt=0, mem[addr_lat]<=din_lat, ready<=1, go to IDLE. ready is low for exactly PROG_CYCLES cycles.
- IDLE -> ERASE: wen fall with cen_s=0, wsen_s=0, cher_s=1. ready<=0, cnt=ERASE_CYCLES-1.
- ERASE: at cnt=0, all words<=16'hFFFF, ready<=1, go to IDLE. Erase may be implemented as a 1-word-per-cycle sweep inside the window, provided the array is complete when ready rises.
- dbo clear: dbo is forced to 0 whenever cen_s=1. dbo holds its last read value while cen_s=0 and no new read completes.
- dbo gating: dbo is driven only when oen_s=0; otherwise the output is 0. The internal data register is unaffected by oen.
- Rejected requests: err_pulse=1 for one cycle at D in these cases:
  - rd_clk_in rise or wen fall while state is not IDLE (request ignored, state/dbo/array unchanged)
  - wen fall with wsen_s=1
  - any strobe with cen_s=1
- Simultaneous rd_clk_in rise and wen fall at the same D in IDLE: the write/erase wins, the read is dropped, err_pulse=1.
- cen_s rising during PROG/ERASE: the operation completes anyway (self-timed).
- Reset mid-operation: PROG aborts with no array update. ERASE aborts with no guarantee on words already swept. ready=1 immediately.
- Address: ADDR_W bits exactly index the array; there is no out-of-range case.
- cnt: 16-bit down-counter shared by all states.

Decomposition:
- Package mtp_pkg:
  - state encoding (IDLE=2'd0, RD_WAIT=2'd1, PROG=2'd2, ERASE=2'd3)
  - ERASE_WORD=16'hFFFF
  - default ADDR_W, DATA_W, timing constants
- Sub-module sync_edge: 2-flop synchronizer plus rise/fall edge pulses, with parameterized reset level. It is instantiated for cen, oen, wen and rd_clk_in; wsen and cher use the sync-only output.

Test Plan:
- Erase: cen=0, wsen=0, cher=1, pulse wen low -> ready=0 for exactly 200 cycles; then a read of addresses 0, 31, 63 returns 16'hFFFF.
- Program/read: program a=6'd5, din=16'hA5C3; wait for ready=1; oen=0, pulse rd_clk_in -> dbo=16'hA5C3 exactly READ_LAT=2 cycles after D; a read of a=6 still returns 16'hFFFF.
- Busy rejection: during PROG of a=1, pulse rd_clk_in and a second wen fall -> err_pulse=1 once per strobe, dbo unchanged, only a=1 is programmed.
- Output gating: after reading 16'h1234, set oen=1 -> dbo=0; oen=0 -> 16'h1234; cen=1 -> dbo=0 and stays 0 after cen=0 until the next read.
- Reset mid-program: program a=9 with 16'h0F0F, assert rst_n low at cycle 10 of PROG -> ready=1 and dbo=0 immediately; a later read of a=9 returns the pre-program value 16'hFFFF.
- Same-cycle strobes: rd_clk_in rise and wen fall land on the same detect cycle with a=3, din=16'h0001 -> err_pulse=1, PROG entered, a later read gives 16'h0001.
